csr_master_arbiter: RTL and testbench

- Round-robin arbiter sharing the single 26-bit CSR Avalon-MM slave port of the CSR address decoder between NUM_REQ Avalon-MM requesters (e.g. host PCIe bridge, JTAG master, on-chip sequencer).
- Exactly one transaction is outstanding at a time.
- A watchdog terminates transactions the decoder never completes and flags the error, so one hung traffic controller cannot lock out the other requesters.
- Sits in the csr_clk domain, directly in front of the decoder's slave interface.

---
 rtl/csr_master_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_csr_master_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_master_arbiter.sv
// csr_master_arbiter: round-robin arbiter that lets NUM_REQ Avalon-MM masters
// share the CSR decoder's single slave port. One transaction is in flight at a
// time, and a watchdog ends any transaction that the decoder never completes.
module csr_master_arbiter #(
   parameter int          NUM_REQ        = 3,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
   input  logic                    csr_clk_clk,
   input  logic                    csr_clk_reset_reset_n,
   input  logic [NUM_REQ*26-1:0]   req_address,
   input  logic [NUM_REQ-1:0]      req_read,
   input  logic [NUM_REQ-1:0]      req_write,
   input  logic [NUM_REQ*32-1:0]   req_writedata,
   output logic [NUM_REQ-1:0]      req_waitrequest,
   output logic [31:0]             req_readdata,
   output logic [NUM_REQ-1:0]      req_readdatavalid,
   output logic [25:0]             m_address,
   output logic                    m_read,
   output logic                    m_write,
   output logic [31:0]             m_writedata,
   input  logic                    m_waitrequest,
   input  logic [31:0]             m_readdata,
   input  logic                    m_readdatavalid,
   output logic                    timeout_error,
   output logic [2:0]              timeout_req,
   input  logic                    timeout_clear
);

   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [NUM_REQ-1:0] ONE = 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RDV = 2'd2,
      TIMEOUT  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           grant_q, grant_d;
   logic [2:0]           last_grant_q, last_grant_d;
   logic                 is_write_q, is_write_d;
   logic                 stall_issue_q, stall_issue_d;
   logic [WDW-1:0]       wdog_q, wdog_d;
   logic [31:0]          readdata_q, readdata_d;
   logic [NUM_REQ-1:0]   rdv_q, rdv_d;
   logic                 terr_q, terr_d;
   logic [2:0]           treq_q, treq_d;

   // Requester buses unpacked into 8-entry tables so a 3-bit grant can index
   // them directly; entries beyond NUM_REQ read as idle.
   logic [25:0]          addr_arr [8];
   logic [31:0]          wdata_arr [8];
   logic [7:0]           pend_pad;
   logic [7:0]           wr_pad;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_unpack
         if (gi < NUM_REQ) begin : g_used
            assign addr_arr[gi]  = req_address[26*gi +: 26];
            assign wdata_arr[gi] = req_writedata[32*gi +: 32];
            assign pend_pad[gi]  = req_read[gi] | req_write[gi];
            assign wr_pad[gi]    = req_write[gi];
         end else begin : g_pad
            assign addr_arr[gi]  = '0;
            assign wdata_arr[gi] = '0;
            assign pend_pad[gi]  = 1'b0;
            assign wr_pad[gi]    = 1'b0;
         end
      end
   endgenerate

   logic [2:0]         pick;
   logic [NUM_REQ-1:0] grant_oh;

   assign grant_oh = ONE << grant_q;

   // Round-robin search: the lowest offset above last_grant that is requesting wins.
   always_comb begin
      logic [2:0] cand;
      cand = '0;
      pick = last_grant_q;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = 3'((int'(last_grant_q) + 1 + k) % NUM_REQ);
         if (pend_pad[cand]) pick = cand;
      end
   end

   // Next-state, datapath mux and per-requester handshake outputs.
   always_comb begin
      state_d         = state_q;
      grant_d         = grant_q;
      last_grant_d    = last_grant_q;
      is_write_d      = is_write_q;
      stall_issue_d   = stall_issue_q;
      wdog_d          = wdog_q;
      readdata_d      = readdata_q;
      rdv_d           = '0;
      terr_d          = terr_q & ~timeout_clear;
      treq_d          = treq_q;
      m_address       = '0;
      m_writedata     = '0;
      m_read          = 1'b0;
      m_write         = 1'b0;
      req_waitrequest = '1;

      case (state_q)
         IDLE: begin
            if (|pend_pad) begin
               grant_d      = pick;
               last_grant_d = pick;
               is_write_d   = wr_pad[pick];
               wdog_d       = WDW'(TIMEOUT_CYCLES - 1);
               state_d      = ISSUE;
            end
         end

         ISSUE: begin
            m_address       = addr_arr[grant_q];
            m_writedata     = wdata_arr[grant_q];
            m_write         = is_write_q;
            m_read          = ~is_write_q;
            req_waitrequest = ~grant_oh | (grant_oh & {NUM_REQ{m_waitrequest}});
            wdog_d          = wdog_q - 1'b1;
            if (!m_waitrequest) begin
               state_d = is_write_q ? IDLE : WAIT_RDV;
            end else if (wdog_q == '0) begin
               state_d       = TIMEOUT;
               stall_issue_d = 1'b1;
               terr_d        = 1'b1;
               treq_d        = grant_q;
               if (!is_write_q) begin
                  readdata_d = TIMEOUT_DATA;
                  rdv_d      = grant_oh;
               end
            end
         end

         WAIT_RDV: begin
            wdog_d = wdog_q - 1'b1;
            if (m_readdatavalid) begin
               readdata_d = m_readdata;
               rdv_d      = grant_oh;
               state_d    = IDLE;
            end else if (wdog_q == '0) begin
               state_d       = TIMEOUT;
               stall_issue_d = 1'b0;
               terr_d        = 1'b1;
               treq_d        = grant_q;
               readdata_d    = TIMEOUT_DATA;
               rdv_d         = grant_oh;
            end
         end

         TIMEOUT: begin
            // A command stalled in ISSUE is completed towards its requester here.
            if (stall_issue_q) req_waitrequest = ~grant_oh;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any transaction in flight.
   always_ff @(posedge csr_clk_clk) begin
      if (!csr_clk_reset_reset_n) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         last_grant_q  <= 3'(NUM_REQ - 1);
         is_write_q    <= 1'b0;
         stall_issue_q <= 1'b0;
         wdog_q        <= '0;
         readdata_q    <= '0;
         rdv_q         <= '0;
         terr_q        <= 1'b0;
         treq_q        <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_grant_q  <= last_grant_d;
         is_write_q    <= is_write_d;
         stall_issue_q <= stall_issue_d;
         wdog_q        <= wdog_d;
         readdata_q    <= readdata_d;
         rdv_q         <= rdv_d;
         terr_q        <= terr_d;
         treq_q        <= treq_d;
      end
   end

   assign req_readdata      = readdata_q;
   assign req_readdatavalid = rdv_q;
   assign timeout_error     = terr_q;
   assign timeout_req       = treq_q;

endmodule

// File: tb/tb_csr_master_arbiter.sv
// Directed bench for csr_master_arbiter: write, read, fairness, both timeout
// paths, late response, error clear and reset mid-read.
module tb_csr_master_arbiter;

   localparam int NR = 3;
   localparam int TO = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NR*26-1:0] req_address = '0;
   logic [NR-1:0]    req_read = '0;
   logic [NR-1:0]    req_write = '0;
   logic [NR*32-1:0] req_writedata = '0;
   logic [NR-1:0]    req_waitrequest;
   logic [31:0]      req_readdata;
   logic [NR-1:0]    req_readdatavalid;
   logic [25:0]      m_address;
   logic             m_read;
   logic             m_write;
   logic [31:0]      m_writedata;
   logic             m_waitrequest = 1'b1;
   logic [31:0]      m_readdata = '0;
   logic             m_readdatavalid = 1'b0;
   logic             timeout_error;
   logic [2:0]       timeout_req;
   logic             timeout_clear = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   csr_master_arbiter #(
      .NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(32'hDEAD_BEEF)
   ) dut (
      .csr_clk_clk(clk),
      .csr_clk_reset_reset_n(rst_n),
      .req_address(req_address),
      .req_read(req_read),
      .req_write(req_write),
      .req_writedata(req_writedata),
      .req_waitrequest(req_waitrequest),
      .req_readdata(req_readdata),
      .req_readdatavalid(req_readdatavalid),
      .m_address(m_address),
      .m_read(m_read),
      .m_write(m_write),
      .m_writedata(m_writedata),
      .m_waitrequest(m_waitrequest),
      .m_readdata(m_readdata),
      .m_readdatavalid(m_readdatavalid),
      .timeout_error(timeout_error),
      .timeout_req(timeout_req),
      .timeout_clear(timeout_clear)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr"},   32'(req_waitrequest), 32'h7);
      check({tag, "_rdv"},  32'(req_readdatavalid), 32'h0);
      check({tag, "_rd"},   req_readdata, 32'h0);
      check({tag, "_mrd"},  32'(m_read), 32'h0);
      check({tag, "_mwr"},  32'(m_write), 32'h0);
      check({tag, "_madr"}, 32'(m_address), 32'h0);
      check({tag, "_mwd"},  m_writedata, 32'h0);
      check({tag, "_terr"}, 32'(timeout_error), 32'h0);
      check({tag, "_treq"}, 32'(timeout_req), 32'h0);
   endtask

   initial begin
      logic [2:0] exp_wr [6];
      logic [25:0] exp_adr [6];
      exp_wr  = '{3'b110, 3'b101, 3'b011, 3'b110, 3'b101, 3'b011};
      exp_adr = '{26'h0000100, 26'h0000200, 26'h0000300,
                  26'h0000100, 26'h0000200, 26'h0000300};

      // ---- reset values ----
      tick(); tick();
      #1 check_reset_outputs("rst");

      // ---- 1: single write from requester 1, decoder stalls 2 cycles ----
      rst_n = 1'b1;
      req_address[26*1 +: 26]   = 26'h0010040;
      req_writedata[32*1 +: 32] = 32'hA5A5_0001;
      req_write = 3'b010;
      m_waitrequest = 1'b1;
      #1 check("t1_idle_wr", 32'(req_waitrequest), 32'h7);
      check("t1_idle_mwr", 32'(m_write), 32'h0);
      tick(); #1;
      check("t1_c1_mwr", 32'(m_write), 32'h1);
      check("t1_c1_adr", 32'(m_address), 32'h0010040);
      check("t1_c1_wd", m_writedata, 32'hA5A5_0001);
      check("t1_c1_wr", 32'(req_waitrequest), 32'h7);
      tick(); #1;
      check("t1_c2_mwr", 32'(m_write), 32'h1);
      check("t1_c2_wr", 32'(req_waitrequest), 32'h7);
      tick(); m_waitrequest = 1'b0; #1;
      check("t1_c3_mwr", 32'(m_write), 32'h1);
      check("t1_c3_wr", 32'(req_waitrequest), 32'h5);
      tick(); req_write = '0; m_waitrequest = 1'b1; #1;
      check("t1_done_mwr", 32'(m_write), 32'h0);
      check("t1_done_wr", 32'(req_waitrequest), 32'h7);

      // ---- 2: read from requester 0, data 3 cycles after accept ----
      tick();
      req_address[26*0 +: 26] = 26'h0200000;
      req_read = 3'b001;
      #1 check("t2_idle_mrd", 32'(m_read), 32'h0);
      tick(); m_waitrequest = 1'b0; #1;
      check("t2_iss_mrd", 32'(m_read), 32'h1);
      check("t2_iss_adr", 32'(m_address), 32'h0200000);
      check("t2_iss_wr", 32'(req_waitrequest), 32'h6);
      tick(); req_read = '0; m_waitrequest = 1'b1; #1;
      check("t2_w1_mrd", 32'(m_read), 32'h0);
      check("t2_w1_rdv", 32'(req_readdatavalid), 32'h0);
      tick();
      tick(); m_readdatavalid = 1'b1; m_readdata = 32'h1234_5678; #1;
      check("t2_w3_rdv", 32'(req_readdatavalid), 32'h0);
      tick(); m_readdatavalid = 1'b0; m_readdata = '0; #1;
      check("t2_rdv", 32'(req_readdatavalid), 32'h1);
      check("t2_rdata", req_readdata, 32'h1234_5678);
      check("t2_idle_wr", 32'(req_waitrequest), 32'h7);
      tick(); #1;
      check("t2_rdv_off", 32'(req_readdatavalid), 32'h0);

      // ---- 3: fairness with all three writing continuously ----
      tick(); rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      req_address[26*0 +: 26] = 26'h0000100;
      req_address[26*1 +: 26] = 26'h0000200;
      req_address[26*2 +: 26] = 26'h0000300;
      req_write = 3'b111;
      m_waitrequest = 1'b0;
      #1 check("t3_idle0_wr", 32'(req_waitrequest), 32'h7);
      for (int i = 0; i < 6; i++) begin
         tick(); #1;
         check($sformatf("t3_gnt%0d_wr", i), 32'(req_waitrequest), 32'(exp_wr[i]));
         check($sformatf("t3_gnt%0d_adr", i), 32'(m_address), 32'(exp_adr[i]));
         tick(); #1;
         check($sformatf("t3_idle%0d_wr", i), 32'(req_waitrequest), 32'h7);
      end
      req_write = '0;
      m_waitrequest = 1'b1;

      // ---- 4: command timeout on a read by requester 2 ----
      tick();
      req_address[26*2 +: 26] = 26'h0000ABC;
      req_read = 3'b100;
      for (int k = 1; k <= TO; k++) begin
         tick();
         if (k == 2) req_write = 3'b001;
         #1;
         check($sformatf("t4_iss%0d_wr", k), 32'(req_waitrequest), 32'h7);
         if (k == 1 || k == TO) check($sformatf("t4_iss%0d_mrd", k), 32'(m_read), 32'h1);
      end
      tick(); #1;
      check("t4_to_wr", 32'(req_waitrequest), 32'h3);
      check("t4_to_rdv", 32'(req_readdatavalid), 32'h4);
      check("t4_to_rdata", req_readdata, 32'hDEAD_BEEF);
      check("t4_to_terr", 32'(timeout_error), 32'h1);
      check("t4_to_treq", 32'(timeout_req), 32'h2);
      check("t4_to_mrd", 32'(m_read), 32'h0);
      tick(); req_read = '0; #1;
      check("t4_idle_wr", 32'(req_waitrequest), 32'h7);
      check("t4_idle_rdv", 32'(req_readdatavalid), 32'h0);
      tick(); m_waitrequest = 1'b0; #1;
      check("t4_next_wr", 32'(req_waitrequest), 32'h6);
      check("t4_next_mwr", 32'(m_write), 32'h1);
      tick(); req_write = '0; m_waitrequest = 1'b1;

      // ---- 5: response timeout, clear in the expiry cycle, late data ----
      tick();
      req_address[26*1 +: 26] = 26'h0000DEF;
      req_read = 3'b010;
      tick(); m_waitrequest = 1'b0; #1;
      check("t5_iss_wr", 32'(req_waitrequest), 32'h5);
      check("t5_iss_mrd", 32'(m_read), 32'h1);
      for (int k = 1; k <= TO - 1; k++) begin
         tick();
         if (k == 1) begin
            req_read = '0;
            m_waitrequest = 1'b1;
         end
         if (k == TO - 1) timeout_clear = 1'b1;
         #1;
         if (k == 1 || k == TO - 1) begin
            check($sformatf("t5_w%0d_mrd", k), 32'(m_read), 32'h0);
            check($sformatf("t5_w%0d_wr", k), 32'(req_waitrequest), 32'h7);
            check($sformatf("t5_w%0d_rdv", k), 32'(req_readdatavalid), 32'h0);
         end
      end
      tick(); timeout_clear = 1'b0; #1;
      check("t5_to_wr", 32'(req_waitrequest), 32'h7);
      check("t5_to_rdv", 32'(req_readdatavalid), 32'h2);
      check("t5_to_rdata", req_readdata, 32'hDEAD_BEEF);
      check("t5_to_terr", 32'(timeout_error), 32'h1);
      check("t5_to_treq", 32'(timeout_req), 32'h1);
      tick(); m_readdatavalid = 1'b1; m_readdata = 32'h55AA_55AA; #1;
      check("t5_late_rdv0", 32'(req_readdatavalid), 32'h0);
      tick(); m_readdatavalid = 1'b0; m_readdata = '0; #1;
      check("t5_late_rdv1", 32'(req_readdatavalid), 32'h0);
      check("t5_late_rdata", req_readdata, 32'hDEAD_BEEF);
      tick(); timeout_clear = 1'b1;
      tick(); timeout_clear = 1'b0; #1;
      check("t5_clr_terr", 32'(timeout_error), 32'h0);
      check("t5_clr_treq", 32'(timeout_req), 32'h1);

      // ---- 6: reset while requester 0's read waits for data ----
      tick();
      req_address[26*0 +: 26] = 26'h0000123;
      req_read = 3'b001;
      tick(); m_waitrequest = 1'b0; #1;
      check("t6_iss_wr", 32'(req_waitrequest), 32'h6);
      tick(); req_read = '0; m_waitrequest = 1'b1; rst_n = 1'b0;
      tick(); #1;
      check_reset_outputs("t6_rst");
      rst_n = 1'b1;
      req_address[26*1 +: 26] = 26'h0000200;
      req_write = 3'b011;
      m_waitrequest = 1'b0;
      tick(); #1;
      check("t6_first_wr", 32'(req_waitrequest), 32'h6);
      check("t6_first_adr", 32'(m_address), 32'h0000123);
      tick();
      tick(); #1;
      check("t6_second_wr", 32'(req_waitrequest), 32'h5);
      req_write = '0;
      m_waitrequest = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
